// File: rtl/int_arbiter.sv
// Interrupt arbiter between device request lines and cp0 HWInt[15:10].
// Define INT_EDGE_EN for edge-triggered pending bits; the default is level-triggered.
module int_arbiter #(
  parameter int NSRC = 6
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [NSRC-1:0] IrqIn,
  input  logic [3:2]      Addr,
  input  logic            We,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  input  logic            exl,
  output logic [15:10]    HWInt,
  output logic [NSRC-1:0] IrqAck
);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t          state_reg;
  logic [NSRC-1:0] pend_reg;
  logic [NSRC-1:0] mask_reg;
  logic [NSRC-1:0] irq_ack_reg;
  logic [2:0]      cur_reg;

  logic [NSRC-1:0] set_vec;
  logic [NSRC-1:0] pend_next;
  logic [NSRC-1:0] cand;
  logic [NSRC-1:0] cur_sel;
  logic [2:0]      cand_idx;
  logic            cur_mask;
  logic            cur_pend;
  logic            ack_hit;
  logic            unused_din;

  assign unused_din = ^Din[31:NSRC];
  assign cand       = pend_reg & mask_reg;

`ifdef INT_EDGE_EN
  logic [NSRC-1:0] irq_prev_reg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      irq_prev_reg <= '0;
    end else begin
      irq_prev_reg <= IrqIn;
    end
  end

  assign set_vec = IrqIn & ~irq_prev_reg;
`else
  assign set_vec = IrqIn;
`endif

  // One-hot view of cur avoids variable indexing; set beats an acknowledge clear.
  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      assign cur_sel[gi]   = (cur_reg == 3'(gi));
      assign pend_next[gi] = set_vec[gi] | (pend_reg[gi] & ~(ack_hit & cur_sel[gi]));
    end
    for (gi = 0; gi < 6; gi++) begin : g_hw
      if (gi < NSRC) begin : g_used
        assign HWInt[10+gi] = (state_reg == REQ) && (cur_reg == 3'(gi));
      end else begin : g_unused
        assign HWInt[10+gi] = 1'b0;
      end
    end
  endgenerate

  assign cur_mask = |(mask_reg & cur_sel);
  assign cur_pend = |(pend_reg & cur_sel);
  assign ack_hit  = (state_reg == SERV) && We && (Addr == 2'd2) &&
                    (|(Din[NSRC-1:0] & cur_sel));
  assign IrqAck   = irq_ack_reg;

  always_comb begin
    cand_idx = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        cand_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg   <= IDLE;
      pend_reg    <= '0;
      mask_reg    <= '0;
      irq_ack_reg <= '0;
      cur_reg     <= 3'd0;
    end else begin
      pend_reg    <= pend_next;
      irq_ack_reg <= '0;
      if (We && (Addr == 2'd1)) begin
        mask_reg <= Din[NSRC-1:0];
      end
      case (state_reg)
        IDLE: begin
          if (|cand) begin
            cur_reg   <= cand_idx;
            state_reg <= REQ;
          end
        end
        REQ: begin
          if (!cur_mask || !cur_pend) begin
            cur_reg   <= 3'd0;
            state_reg <= IDLE;
          end else if (exl) begin
            state_reg <= SERV;
          end
        end
        SERV: begin
          // exl was 1 on entry, so a low exl here is the falling edge
          if (ack_hit) begin
            irq_ack_reg <= cur_sel;
            cur_reg     <= 3'd0;
            state_reg   <= IDLE;
          end else if (!exl) begin
            cur_reg   <= 3'd0;
            state_reg <= IDLE;
          end
        end
        default: begin
          cur_reg   <= 3'd0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr)
      2'd0: Dout[NSRC-1:0] = pend_reg;
      2'd1: Dout[NSRC-1:0] = mask_reg;
      2'd3: begin
        Dout[31]  = (state_reg != IDLE);
        Dout[2:0] = cur_reg;
      end
      default: Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_int_arbiter.sv
// Scoreboard bench for int_arbiter: a reference model predicts every cycle,
// a monitor on the falling edge compares HWInt, IrqAck and Dout.
module tb_int_arbiter;
  localparam int N = 6;

  logic          Clk;
  logic          Reset;
  logic [N-1:0]  IrqIn;
  logic [3:2]    Addr;
  logic          We;
  logic [31:0]   Din;
  logic [31:0]   Dout;
  logic          exl;
  logic [15:10]  HWInt;
  logic [N-1:0]  IrqAck;

  int_arbiter #(.NSRC(N)) dut (
    .Clk(Clk), .Reset(Reset), .IrqIn(IrqIn), .Addr(Addr), .We(We),
    .Din(Din), .Dout(Dout), .exl(exl), .HWInt(HWInt), .IrqAck(IrqAck)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit [5:0]  hw;
    bit [5:0]  ack;
    bit [31:0] dout;
    int        cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;

  // Reference model: m_cur = -1 when nothing is selected, m_served = cp0 has taken it
  bit [5:0] m_pend, m_mask, m_ack, m_prev;
  int       m_cur;
  bit       m_served;

  function automatic bit [31:0] model_dout(bit [1:0] a);
    case (a)
      2'd0: return {26'd0, m_pend};
      2'd1: return {26'd0, m_mask};
      2'd3: return (m_cur >= 0) ? (32'h8000_0000 | 32'(m_cur)) : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_step(bit rst, bit [5:0] irq, bit [1:0] a, bit w,
                                     bit [31:0] d, bit x);
    bit [5:0] setb;
    bit [5:0] cand;
    bit       ack_ok;
    int       old_cur;
    int       lowest;
    if (rst) begin
      m_pend = 0; m_mask = 0; m_ack = 0; m_prev = 0; m_cur = -1; m_served = 0;
      return;
    end
`ifdef INT_EDGE_EN
    setb = irq & ~m_prev;
`else
    setb = irq;
`endif
    m_prev  = irq;
    old_cur = m_cur;
    ack_ok  = w && (a == 2'd2) && (m_cur >= 0) && m_served && d[m_cur];
    cand    = m_pend & m_mask;
    if (m_cur < 0) begin
      lowest = -1;
      for (int i = 0; i < N; i++) if (cand[i] && lowest < 0) lowest = i;
      if (lowest >= 0) begin m_cur = lowest; m_served = 0; end
    end else if (!m_served) begin
      if (!m_mask[m_cur] || !m_pend[m_cur]) m_cur = -1;
      else if (x) m_served = 1;
    end else if (ack_ok || !x) begin
      m_cur = -1; m_served = 0;
    end
    m_ack = ack_ok ? (6'b1 << old_cur) : 6'd0;
    if (ack_ok) m_pend = m_pend & ~(6'b1 << old_cur);
    m_pend = m_pend | setb;
    if (w && a == 2'd1) m_mask = d[5:0];
  endfunction

  // Called just after a rising edge: drive, record expectation, advance model.
  task automatic cyc(input bit rst, input bit [5:0] irq, input bit [1:0] a,
                     input bit w, input bit [31:0] d, input bit x);
    exp_t e;
    Reset = rst; IrqIn = irq; Addr = a; We = w; Din = d; exl = x;
    e.hw   = (m_cur >= 0 && !m_served) ? (6'b1 << m_cur) : 6'd0;
    e.ack  = m_ack;
    e.dout = model_dout(a);
    e.cyc  = cyc_n;
    exp_q.push_back(e);
    model_step(rst, irq, a, w, d, x);
    cyc_n++;
    @(posedge Clk);
    #1;
  endtask

  initial begin : monitor
    exp_t     e;
    bit [5:0] hw_got;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        hw_got = HWInt;
        checks++;
        if (hw_got !== e.hw) begin
          errors++;
          $display("FAIL hwint cyc=%0d got=%b exp=%b", e.cyc, hw_got, e.hw);
        end
        checks++;
        if (IrqAck !== e.ack) begin
          errors++;
          $display("FAIL irqack cyc=%0d got=%b exp=%b", e.cyc, IrqAck, e.ack);
        end
        checks++;
        if (Dout !== e.dout) begin
          errors++;
          $display("FAIL dout cyc=%0d addr=%0d got=%h exp=%h", e.cyc, Addr, Dout, e.dout);
        end
        if (e.ack != 0) $display("ack cyc=%0d vec=%b", e.cyc, e.ack);
      end
    end
  end

  initial begin : driver
    bit       xs;
    bit [5:0] irq;
    bit [1:0] a;
    bit       w;
    bit [31:0] d;
    int       r;
    Reset = 1'b1; IrqIn = '0; Addr = '0; We = 1'b0; Din = '0; exl = 1'b0;
    m_pend = 0; m_mask = 0; m_ack = 0; m_prev = 0; m_cur = -1; m_served = 0;
    @(posedge Clk);
    #1;
    // Reset state on every address, while and after reset
    for (int i = 0; i < 4; i++) cyc(1, 0, 2'(i), 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 2'(i), 0, 0, 0);
    // Single source 2: request, service, acknowledge, repeated ack ignored
    cyc(0, 0, 1, 1, 32'h3F, 0);
    cyc(0, 6'h04, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 3, 0, 0, 0);
    cyc(0, 0, 3, 0, 0, 1);
    cyc(0, 0, 3, 0, 0, 1);
    cyc(0, 0, 2, 1, 32'h04, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 2, 1, 32'h04, 1);
    cyc(0, 0, 3, 0, 0, 0);
    // Sources 1 and 4 together: lowest first
    cyc(0, 6'h12, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 3, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 3, 0, 0, 1);
    cyc(0, 0, 2, 1, 32'h02, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 3, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 3, 0, 0, 1);
    cyc(0, 0, 2, 1, 32'h10, 1);
    cyc(0, 0, 0, 0, 0, 0);
    // Mask withdrawal while source 3 is requested
    cyc(0, 6'h08, 0, 0, 0, 0);
    cyc(0, 0, 3, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h37, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 3, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'hFFFF_FF3F, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 3, 0, 0, 1);
    cyc(0, 0, 2, 1, 32'h08, 1);
    cyc(0, 0, 0, 0, 0, 0);
    // Source 0 held high through its acknowledge
    for (int i = 0; i < 3; i++) cyc(0, 6'h01, 3, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 6'h01, 3, 0, 0, 1);
    cyc(0, 6'h01, 2, 1, 32'h01, 1);
    for (int i = 0; i < 2; i++) cyc(0, 6'h01, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 6'h01, 3, 0, 0, 0);
    cyc(0, 0, 3, 0, 0, 1);
    cyc(0, 0, 2, 1, 32'h01, 1);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0, 0);
    // Reset while in service
    cyc(0, 6'h20, 0, 0, 0, 0);
    cyc(0, 0, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 3, 0, 0, 1);
    cyc(1, 0, 3, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h3F, 0);
    // Randomised traffic with a crude cp0 that raises exl when requested
    xs = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) irq[i] = ($urandom_range(0, 9) == 0);
      if (m_cur >= 0 && !m_served) xs = ($urandom_range(0, 9) < 6) ? 1'b1 : xs;
      else if (m_served) xs = ($urandom_range(0, 9) < 2) ? 1'b0 : xs;
      else xs = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 99);
      a = 2'($urandom_range(0, 3));
      w = 1'b0;
      d = $urandom;
      if (r < 5) begin
        a = 2'd1; w = 1'b1;
        if ($urandom_range(0, 1) == 0) d = 32'h3F;
      end else if (r < 25) begin
        a = 2'd2; w = 1'b1;
        if (m_cur >= 0 && $urandom_range(0, 9) < 7) d = d | (32'd1 << m_cur);
      end else if (r < 27) begin
        w = 1'b1;
      end
      cyc(($urandom_range(0, 299) == 0), irq, a, w, d, xs);
    end
    @(negedge Clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d left exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
